// File: rtl/fifo_rr_controller.sv
// Round-robin write arbiter and pop sequencer in front of a single-clock FIFO.
// Occupancy is tracked locally so the FIFO never sees an overflow or an underflow.
module fifo_rr_controller #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int LVLW  = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       ack,
  input  logic                   pop,
  output logic                   pop_ack,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   fifo_write_req,
  output logic [WIDTH-1:0]       fifo_write_data,
  output logic                   fifo_read_req,
  input  logic [WIDTH-1:0]       fifo_read_data,
  input  logic                   fifo_full,
  input  logic                   fifo_empty,
  output logic [LVLW-1:0]        level,
  output logic                   err
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [LVLW-1:0] DEPTH_L = LVLW'(DEPTH);

  logic [GW-1:0]    last_grant;
  logic [GW-1:0]    grant;
  logic             found;
  logic             space;
  logic             wr_acc;
  logic [WIDTH-1:0] slice [N_REQ];
  logic             flags_bad;

  // NOTE: every signal assigned in always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      logic [GW-1:0] idx;
      idx = GW'((int'(last_grant) + k) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      slice[i] = wdata[i*WIDTH +: WIDTH];
    end
  end

  // A pop in this cycle does not free space until level has been updated.
  assign space   = (level < DEPTH_L);
  assign wr_acc  = found && space;
  assign ack     = wr_acc ? (N_REQ'(1) << grant) : '0;
  assign pop_ack = pop && (level != '0);
  assign rd_data = fifo_read_data;

  // Flags are only meaningful against level when no strobe is still in flight.
  assign flags_bad = !fifo_write_req && !fifo_read_req &&
                     ((fifo_empty != (level == '0)) || (fifo_full != (level == DEPTH_L)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant      <= GW'(N_REQ - 1);
      fifo_write_req  <= 1'b0;
      fifo_write_data <= '0;
      fifo_read_req   <= 1'b0;
      rd_valid        <= 1'b0;
      level           <= '0;
      err             <= 1'b0;
    end else begin
      fifo_write_req <= wr_acc;
      if (wr_acc) begin
        fifo_write_data <= slice[grant];
        last_grant      <= grant;
      end
      fifo_read_req <= pop_ack;
      rd_valid      <= fifo_read_req;
      case ({wr_acc, pop_ack})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (flags_bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rr_controller.sv
// Directed bench for fifo_rr_controller with a behavioural FIFO behind it;
// expected write/read data go into queues that a negedge monitor drains.
module tb_fifo_rr_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  ack;
  logic        pop;
  logic        pop_ack;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        fifo_write_req;
  logic [7:0]  fifo_write_data;
  logic        fifo_read_req;
  logic [7:0]  fifo_read_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic [8:0]  level;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [7:0] wr_q[$];
  logic [7:0] rd_q[$];

  fifo_rr_controller #(.N_REQ(4), .WIDTH(8), .DEPTH(256), .LVLW(9)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .ack(ack),
    .pop(pop), .pop_ack(pop_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_write_req(fifo_write_req), .fifo_write_data(fifo_write_data),
    .fifo_read_req(fifo_read_req), .fifo_read_data(fifo_read_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .level(level), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: registered read data, no overflow/underflow protection.
  logic [7:0] mem [256];
  logic [7:0] wp, rp;
  logic [8:0] cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0; rp <= '0; cnt <= '0; fifo_read_data <= '0;
    end else begin
      if (fifo_write_req) begin
        mem[wp] <= fifo_write_data;
        wp      <= wp + 8'd1;
      end
      if (fifo_read_req) begin
        fifo_read_data <= mem[rp];
        rp             <= rp + 8'd1;
      end
      cnt <= cnt + 9'(fifo_write_req) - 9'(fifo_read_req);
    end
  end
  assign fifo_empty = (cnt == 9'd0);
  assign fifo_full  = (cnt == 9'd256);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every write/read strobe against the scoreboard queues.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (fifo_write_req) begin
        check("wr_while_full", 32'(fifo_full), 32'd0);
        if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else check("fifo_write_data", 32'(fifo_write_data), 32'(wr_q.pop_front()));
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    req   = '0;
    pop   = 1'b0;
    wdata = 32'h13121110;
    repeat (3) tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wreq", 32'(fifo_write_req), 32'd0);
    check("rst_wdata", 32'(fifo_write_data), 32'd0);
    check("rst_rreq", 32'(fifo_read_req), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    reset = 1'b1;
    tick();

    // Round robin across all four ports from port 0.
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_ack", 32'(ack), 32'(4'b0001 << (k % 4)));
      wr_q.push_back(8'h10 + 8'(k % 4));
      tick();
    end
    req = '0;
    check("rr_level", 32'(level), 32'd8);
    for (int k = 0; k < 8; k++) begin
      pop = 1'b1;
      #1;
      check("rr_pop_ack", 32'(pop_ack), 32'd1);
      rd_q.push_back(8'h10 + 8'(k % 4));
      tick();
    end
    pop = 1'b0;
    repeat (3) tick();
    check("rr_drained", 32'(level), 32'd0);

    // Single requester on port 2, then pointer must move on to port 3.
    req = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("p2_ack", 32'(ack), 32'b0100);
      wr_q.push_back(8'h12);
      tick();
      check("p2_level", 32'(level), 32'(k + 1));
    end
    req = 4'b1111;
    #1;
    check("p2_next_grant", 32'(ack), 32'b1000);
    wr_q.push_back(8'h13);
    tick();
    req = '0;
    for (int k = 0; k < 6; k++) begin
      pop = 1'b1;
      #1;
      rd_q.push_back(k < 5 ? 8'h12 : 8'h13);
      tick();
    end
    pop = 1'b0;
    repeat (3) tick();
    check("p2_drained", 32'(level), 32'd0);

    // Fill to DEPTH from port 0 with distinct data.
    req = 4'b0001;
    for (int k = 0; k < 256; k++) begin
      wdata[7:0] = 8'(k);
      #1;
      if (ack !== 4'b0001) check("fill_ack", 32'(ack), 32'b0001);
      wr_q.push_back(8'(k));
      tick();
    end
    #1;
    check("full_ack", 32'(ack), 32'd0);
    check("full_level", 32'(level), 32'd256);
    repeat (3) tick();
    check("full_flag", 32'(fifo_full), 32'd1);
    check("full_ack_held", 32'(ack), 32'd0);
    check("full_err", 32'(err), 32'd0);

    // At DEPTH: pop wins, write waits one cycle.
    req = 4'b0010;
    pop = 1'b1;
    #1;
    check("full_pop_ack", 32'(pop_ack), 32'd1);
    check("full_req_ack", 32'(ack), 32'd0);
    rd_q.push_back(8'h00);
    tick();
    pop = 1'b0;
    check("full_pop_level", 32'(level), 32'd255);
    #1;
    check("after_pop_ack", 32'(ack), 32'b0010);
    wr_q.push_back(8'h11);
    tick();
    req = '0;
    check("refill_level", 32'(level), 32'd256);
    for (int k = 0; k < 256; k++) begin
      pop = 1'b1;
      #1;
      if (pop_ack !== 1'b1) check("drain_pop_ack", 32'(pop_ack), 32'd1);
      rd_q.push_back(k < 255 ? 8'(k + 1) : 8'h11);
      tick();
    end
    #1;
    check("empty_pop_refused", 32'(pop_ack), 32'd0);
    tick();
    pop = 1'b0;
    repeat (3) tick();
    check("drain_level", 32'(level), 32'd0);
    check("drain_empty", 32'(fifo_empty), 32'd1);
    check("drain_err", 32'(err), 32'd0);

    // First write and a same-cycle pop, then pop on the next cycle.
    wdata[7:0] = 8'hA5;
    req = 4'b0001;
    pop = 1'b1;
    #1;
    check("a5_ack", 32'(ack), 32'b0001);
    check("a5_first_pop", 32'(pop_ack), 32'd0);
    wr_q.push_back(8'hA5);
    tick();
    req = '0;
    #1;
    check("a5_pop_ack", 32'(pop_ack), 32'd1);
    rd_q.push_back(8'hA5);
    tick();
    pop = 1'b0;
    check("a5_rreq", 32'(fifo_read_req), 32'd1);
    check("a5_rd_valid_early", 32'(rd_valid), 32'd0);
    check("a5_level", 32'(level), 32'd0);
    tick();
    check("a5_rd_valid", 32'(rd_valid), 32'd1);
    check("a5_rd_data", 32'(rd_data), 32'hA5);
    check("a5_empty", 32'(fifo_empty), 32'd1);
    repeat (2) tick();

    // Mid-stream asynchronous reset at level 37 with a write and pop in flight.
    req = 4'b0001;
    for (int k = 0; k < 37; k++) begin
      wdata[7:0] = 8'h40 + 8'(k);
      wr_q.push_back(8'h40 + 8'(k));
      tick();
    end
    req = '0;
    check("pre_rst_level", 32'(level), 32'd37);
    pop = 1'b1;
    #1;
    reset = 1'b0;
    wr_q.delete();
    rd_q.delete();
    #1;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_wreq", 32'(fifo_write_req), 32'd0);
    check("mid_rst_rreq", 32'(fifo_read_req), 32'd0);
    check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_pop_ack", 32'(pop_ack), 32'd0);
    pop = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    pop = 1'b1;
    #1;
    check("post_rst_pop", 32'(pop_ack), 32'd0);
    tick();
    wdata[7:0] = 8'h5C;
    req = 4'b0001;
    #1;
    check("post_rst_ack", 32'(ack), 32'b0001);
    check("post_rst_pop2", 32'(pop_ack), 32'd0);
    wr_q.push_back(8'h5C);
    tick();
    req = '0;
    #1;
    check("post_rst_pop3", 32'(pop_ack), 32'd1);
    rd_q.push_back(8'h5C);
    tick();
    pop = 1'b0;
    repeat (4) tick();
    check("final_level", 32'(level), 32'd0);
    check("final_err", 32'(err), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rr_controller.md
Name: fifo_rr_controller

Overview:
Shares one 8-bit, 256-deep FIFO datapath between N_REQ producers using a round-robin write arbiter. Sequences the single consumer's pops into the FIFO's read port. Tracks occupancy internally, so the FIFO never sees a write when full or a read when empty; the FIFO itself has no overflow or underflow protection. Sits directly in front of the FIFO and shares its clock and reset.

Parameters:
N_REQ, 4, number of producer ports (2..8)
WIDTH, 8, data width; matches the FIFO data width
DEPTH, 256, FIFO capacity in entries
LVLW, 9, occupancy counter width; must be at least clog2(DEPTH+1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
req  input  N_REQ  producer i has data; held until ack[i]
wdata  input  N_REQ*WIDTH  producer data; slice i = wdata[i*WIDTH +: WIDTH]
ack  output  N_REQ  combinational one-hot; data of port i accepted at this edge
pop  input  1  consumer read request
pop_ack  output  1  combinational; pop accepted at this edge
rd_data  output  WIDTH  read data (FIFO read_data passthrough)
rd_valid  output  1  rd_data valid this cycle
fifo_write_req  output  1  registered write strobe to the FIFO
fifo_write_data  output  WIDTH  registered write data to the FIFO
fifo_read_req  output  1  registered read strobe to the FIFO
fifo_read_data  input  WIDTH  FIFO read_data
fifo_full, fifo_empty  input  1  FIFO flags; used only for error checking
level  output  LVLW  accepted writes minus accepted pops
err  output  1  sticky; level disagrees with the FIFO flags

Behaviour:
- Reset (reset=0, asynchronous): these go to 0 — fifo_write_req, fifo_write_data, fifo_read_req, rd_valid, level, err.
- Reset also sets the round-robin pointer last_grant to N_REQ-1, so port 0 has top priority after reset.
- The FIFO is on the same reset, so a mid-operation reset leaves both sides empty and consistent. In-flight acks and pops are discarded; rd_valid does not fire for them.
- Write acceptance: space = (level < DEPTH).
  - Grant goes to the first i with req[i]=1, searching from (last_grant+1) mod N_REQ upward with wrap.
  - ack[grant] = space.
  - On an accepting edge: fifo_write_data <= wdata slice, fifo_write_req <= 1, last_grant <= grant.
  - Otherwise fifo_write_req <= 0.
  - At most one write per cycle.
- If no req, or space=0: ack is all zeros and last_grant holds.
- Pop acceptance: pop_ack = pop & (level != 0); fifo_read_req <= pop_ack.
  - level counts the write accepted in the same cycle only from the next cycle on. A pop in the same cycle as the first write is refused (pop_ack=0).
- Write and read strobes have equal one-cycle register latency, so FIFO ordering matches acceptance order.
- Read latency: rd_valid <= fifo_read_req, i.e. rd_valid is high 2 cycles after a pop_ack edge. rd_data = fifo_read_data.
- level update on each edge:
  - +1 on write accept only
  - -1 on pop accept only
  - unchanged when both or neither
- A pop is not credited toward space in the same cycle. At level==DEPTH, a simultaneous req and pop give pop_ack=1 and ack=0.
- Throughput: 1 write and 1 read per cycle sustained.
- err is set and held when, with no strobe in flight (fifo_write_req=0 and fifo_read_req=0), either:
  - fifo_empty != (level==0), or
  - fifo_full != (level==DEPTH).
- err clears only on reset.
- pop with level==0 is simply refused; it is not an error.

Test Plan:
- Reset, then req=4'b1111 held with port data 0x10,0x11,0x12,0x13 -> ack order 0,1,2,3,0,...; fifo_write_data sequence 0x10,0x11,0x12,0x13 one cycle after each ack.
- Only req[2] held for 5 cycles -> ack[2]=1 every cycle; level increments 1..5; last_grant stays 2.
- Fill to 256 with continuous req[0] -> ack stops at level=256, fifo_full=1, fifo_write_req never asserts with full; err=0.
- Write 0xA5 then pop on the next cycle -> pop_ack=1; rd_valid=1 two cycles later with rd_data=0xA5; level back to 0, fifo_empty=1.
- level=256 with req[1] and pop asserted together -> pop_ack=1, ack=0, level=255. Next cycle req[1] is accepted and level=256.
- Mid-stream reset with level=37 -> level=0, rd_valid=0 and all strobes 0 immediately (asynchronous). After release, a pop is refused until the first write.
